// File: rtl/operand_fetch.sv
// operand_fetch: reads register operands, tracks in-flight destinations and stalls on RAW hazards
module operand_fetch #(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32,
    parameter int CTRLW     = 16,
    localparam int AW       = $clog2(NUMREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AW-1:0]        in_rs1_i,
    input  logic [AW-1:0]        in_rs2_i,
    input  logic                 in_use_rs1_i,
    input  logic                 in_use_rs2_i,
    input  logic [AW-1:0]        in_rd_i,
    input  logic                 in_wr_rd_i,
    input  logic [DATAWIDTH-1:0] in_imm_i,
    input  logic [CTRLW-1:0]     in_ctrl_i,
    output logic                 re_a_o,
    output logic [AW-1:0]        raddr_a_o,
    input  logic [DATAWIDTH-1:0] rdata_a_i,
    output logic                 re_b_o,
    output logic [AW-1:0]        raddr_b_o,
    input  logic [DATAWIDTH-1:0] rdata_b_i,
    input  logic                 wb_we_i,
    input  logic [AW-1:0]        wb_waddr_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] out_op_a_o,
    output logic [DATAWIDTH-1:0] out_op_b_o,
    output logic [AW-1:0]        out_rd_o,
    output logic                 out_wr_rd_o,
    output logic [DATAWIDTH-1:0] out_imm_o,
    output logic [CTRLW-1:0]     out_ctrl_o
);
    logic [NUMREGS-1:0]   busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic                 wr_rd_q, wr_rd_d;
    logic [CTRLW-1:0]     ctrl_q, ctrl_d;
    logic                 haz_a, haz_b, accept, issue;

    assign raddr_a_o = in_rs1_i;
    assign raddr_b_o = in_rs2_i;
    assign re_a_o    = in_valid_i & in_use_rs1_i;
    assign re_b_o    = in_valid_i & in_use_rs2_i;

    // A same-cycle writeback is bypassed by the bank, so only an unresolved busy bit or the held rd stalls
    assign haz_a = in_use_rs1_i && (in_rs1_i != '0) &&
                   ((busy_q[in_rs1_i] && !(wb_we_i && wb_waddr_i == in_rs1_i)) ||
                    (out_valid_q && wr_rd_q && rd_q == in_rs1_i));
    assign haz_b = in_use_rs2_i && (in_rs2_i != '0) &&
                   ((busy_q[in_rs2_i] && !(wb_we_i && wb_waddr_i == in_rs2_i)) ||
                    (out_valid_q && wr_rd_q && rd_q == in_rs2_i));

    assign in_ready_o = !haz_a && !haz_b && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign issue      = out_valid_q && out_ready_i;

    assign out_valid_o = out_valid_q;
    assign out_op_a_o  = op_a_q;
    assign out_op_b_o  = op_b_q;
    assign out_rd_o    = rd_q;
    assign out_wr_rd_o = wr_rd_q;
    assign out_imm_o   = imm_q;
    assign out_ctrl_o  = ctrl_q;

    // Next state: scoreboard set beats clear, flush wipes everything, accept loads the output register
    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        wr_rd_d     = wr_rd_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            busy_d      = '0;
        end else begin
            if (wb_we_i) busy_d[wb_waddr_i] = 1'b0;
            if (issue && wr_rd_q) busy_d[rd_q] = 1'b1;
            busy_d[0] = 1'b0;
            if (accept) begin
                out_valid_d = 1'b1;
                op_a_d      = in_use_rs1_i ? rdata_a_i : '0;
                op_b_d      = in_use_rs2_i ? rdata_b_i : '0;
                rd_d        = in_rd_i;
                wr_rd_d     = in_wr_rd_i;
                imm_d       = in_imm_i;
                ctrl_d      = in_ctrl_i;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            wr_rd_q     <= 1'b0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
            wr_rd_q     <= wr_rd_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a behavioural model
module tb_operand_fetch;
    localparam int NR = 32, DW = 32, CW = 16, AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, use1, use2, wr, re_a, re_b, wb_we, flush;
    logic [AW-1:0] rs1, rs2, rd, raddr_a, raddr_b, wb_waddr;
    logic [DW-1:0] imm, rdata_a, rdata_b, wb_wdata;
    logic [CW-1:0] ctrl;
    logic out_valid, out_ready, out_wr;
    logic [DW-1:0] out_a, out_b, out_imm;
    logic [AW-1:0] out_rd;
    logic [CW-1:0] out_ctrl;

    logic [DW-1:0] bank [NR];

    bit            m_busy [NR];
    bit            m_hv, m_wr;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [AW-1:0] m_rd;
    logic [CW-1:0] m_ctrl;
    logic [AW-1:0] pend [$];
    int n_vec = 0, n_bad = 0;

    operand_fetch dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs1_i(rs1), .in_rs2_i(rs2), .in_use_rs1_i(use1), .in_use_rs2_i(use2),
        .in_rd_i(rd), .in_wr_rd_i(wr), .in_imm_i(imm), .in_ctrl_i(ctrl),
        .re_a_o(re_a), .raddr_a_o(raddr_a), .rdata_a_i(rdata_a),
        .re_b_o(re_b), .raddr_b_o(raddr_b), .rdata_b_i(rdata_b),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_op_a_o(out_a), .out_op_b_o(out_b), .out_rd_o(out_rd),
        .out_wr_rd_o(out_wr), .out_imm_o(out_imm), .out_ctrl_o(out_ctrl)
    );

    always #5 clk = ~clk;

    // Register bank: x[i]=i after reset, written on writeback, combinational read with bypass
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < NR; i++) bank[i] <= DW'(i);
        else if (wb_we && wb_waddr != '0) bank[wb_waddr] <= wb_wdata;
    end
    assign rdata_a = (raddr_a == '0) ? '0 : (wb_we && wb_waddr == raddr_a) ? wb_wdata : bank[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : (wb_we && wb_waddr == raddr_b) ? wb_wdata : bank[raddr_b];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bank_rd(input logic [AW-1:0] s);
        if (s == '0) return '0;
        if (wb_we && wb_waddr == s) return wb_wdata;
        return bank[s];
    endfunction

    function automatic bit blocked(input logic [AW-1:0] s, input bit u);
        return u && s != '0 && ((m_busy[s] && !(wb_we && wb_waddr == s)) || (m_hv && m_wr && m_rd == s));
    endfunction

    function automatic bit exp_ready();
        return !blocked(rs1, use1) && !blocked(rs2, use2) && (!m_hv || out_ready) && !flush;
    endfunction

    task automatic model_reset();
        m_hv = 0; m_wr = 0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
        for (int i = 0; i < NR; i++) m_busy[i] = 0;
        pend.delete();
    endtask

    // One clock: compare every output at the falling edge, then advance the model across the rising edge
    task automatic cyc();
        bit rdy, acc, iss, n_hv, n_wr;
        bit nb [NR];
        logic [DW-1:0] n_a, n_b, n_imm;
        logic [AW-1:0] n_rd;
        logic [CW-1:0] n_ctrl;
        @(negedge clk);
        rdy = exp_ready();
        chk("in_ready", in_ready, rdy);
        chk("re_a", re_a, in_valid & use1);
        chk("raddr_a", raddr_a, rs1);
        chk("re_b", re_b, in_valid & use2);
        chk("raddr_b", raddr_b, rs2);
        chk("out_valid", out_valid, m_hv);
        chk("op_a", out_a, m_a);
        chk("op_b", out_b, m_b);
        chk("out_rd", out_rd, m_rd);
        chk("out_wr", out_wr, m_wr);
        chk("out_imm", out_imm, m_imm);
        chk("out_ctrl", out_ctrl, m_ctrl);
        acc = in_valid && rdy;
        iss = m_hv && out_ready;
        nb = m_busy;
        n_hv = m_hv; n_wr = m_wr; n_a = m_a; n_b = m_b; n_imm = m_imm; n_rd = m_rd; n_ctrl = m_ctrl;
        if (flush) begin
            n_hv = 0;
            for (int i = 0; i < NR; i++) nb[i] = 0;
            pend.delete();
        end else begin
            if (wb_we) nb[wb_waddr] = 0;
            if (iss && m_wr && m_rd != '0) begin
                nb[m_rd] = 1;
                pend.push_back(m_rd);
            end
            if (acc) begin
                n_hv = 1; n_wr = wr; n_rd = rd; n_imm = imm; n_ctrl = ctrl;
                n_a = use1 ? bank_rd(rs1) : '0;
                n_b = use2 ? bank_rd(rs2) : '0;
            end else if (out_ready) n_hv = 0;
        end
        @(posedge clk);
        m_busy = nb;
        m_hv = n_hv; m_wr = n_wr; m_a = n_a; m_b = n_b; m_imm = n_imm; m_rd = n_rd; m_ctrl = n_ctrl;
        #1;
    endtask

    task automatic drv(input bit v, input logic [AW-1:0] r1, input bit u1, input logic [AW-1:0] r2,
                       input bit u2, input logic [AW-1:0] d, input bit w, input logic [DW-1:0] im,
                       input logic [CW-1:0] ct, input bit ordy);
        in_valid = v; rs1 = r1; use1 = u1; rs2 = r2; use2 = u2; rd = d; wr = w;
        imm = im; ctrl = ct; out_ready = ordy; wb_we = 0; wb_waddr = '0; wb_wdata = '0; flush = 0;
    endtask

    initial begin
        rst = 1;
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        model_reset();
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_op_a", out_a, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1 rst = 0;

        // Simple issue: x3 and x4
        drv(1, 3, 1, 4, 1, 10, 0, 32'h11, 16'h22, 1);
        #1 chk("t1_ready", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t1_valid", out_valid, 1); chk("t1_op_a", out_a, 3); chk("t1_op_b", out_b, 4);
        cyc();

        // RAW on x5: held rd, then busy bit, then writeback bypass
        drv(1, 0, 0, 0, 0, 5, 1, 32'h1, 16'h1, 0);
        #1 chk("t2_i0_ready", in_ready, 1);
        cyc();
        drv(1, 5, 1, 0, 0, 6, 0, 32'h33, 16'h44, 0);
        #1 chk("t2_held_stall", in_ready, 0);
        cyc();
        #1 chk("t2_held_stall2", in_ready, 0);
        cyc();
        out_ready = 1;
        #1 chk("t2_issue_stall", in_ready, 0);
        cyc();
        #1 chk("t2_busy_stall", in_ready, 0);
        cyc();
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hABCD;
        #1 chk("t2_bypass_ready", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t2_valid", out_valid, 1); chk("t2_op_a", out_a, 32'hABCD);
        cyc();

        // Backpressure for four cycles
        drv(1, 1, 1, 2, 1, 11, 1, 32'h55, 16'h66, 0);
        cyc();
        drv(1, 3, 1, 4, 1, 12, 0, 32'h77, 16'h88, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_valid", out_valid, 1); chk("t3_op_a", out_a, 1); chk("t3_op_b", out_b, 2);
            chk("t3_rd", out_rd, 11); chk("t3_ctrl", out_ctrl, 16'h66); chk("t3_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1;
        #1 chk("t3_release", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t3_next_op_a", out_a, 3);
        cyc();

        // x0 is never a hazard
        drv(1, 0, 0, 0, 0, 0, 1, 32'h2, 16'h2, 0);
        cyc();
        drv(1, 0, 1, 0, 0, 13, 0, 32'h3, 16'h3, 1);
        #1 chk("t4_x0_ready", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t4_valid", out_valid, 1); chk("t4_op_a", out_a, 0);
        cyc();

        // Flush with busy x7 and a held instruction
        drv(1, 0, 0, 0, 0, 7, 1, 32'h4, 16'h4, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        cyc();
        drv(1, 0, 0, 0, 0, 8, 1, 32'h5, 16'h5, 0);
        cyc();
        drv(1, 7, 1, 0, 0, 14, 0, 32'h99, 16'hAA, 0);
        #1 chk("t5_pre_stall", in_ready, 0);
        flush = 1;
        #1 chk("t5_flush_ready", in_ready, 0);
        cyc();
        flush = 0;
        #1 chk("t5_valid_cleared", out_valid, 0); chk("t5_ready", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t5_valid", out_valid, 1); chk("t5_op_a", out_a, 7);
        cyc();

        // Asynchronous reset with busy x9 and a held instruction
        drv(1, 0, 0, 0, 0, 9, 1, 32'h6, 16'h6, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        cyc();
        drv(1, 0, 0, 0, 0, 12, 1, 32'hBB, 16'hCC, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        #1 chk("t6_held", out_valid, 1);
        #1 rst = 1;
        #1 chk("t6_async_valid", out_valid, 0); chk("t6_async_imm", out_imm, 0); chk("t6_async_rd", out_rd, 0);
        model_reset();
        @(posedge clk); #1 rst = 0;
        drv(1, 9, 1, 0, 0, 15, 0, 32'h7, 16'h7, 1);
        #1 chk("t6_ready", in_ready, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        #1 chk("t6_op_a", out_a, 9);
        cyc();

        // Random traffic with a downstream that writes back issued destinations
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            rs1       = AW'($urandom_range(7));
            rs2       = AW'($urandom_range(7));
            use1      = $urandom_range(1) != 0;
            use2      = $urandom_range(1) != 0;
            rd        = AW'($urandom_range(7));
            wr        = $urandom_range(1) != 0;
            imm       = $urandom;
            ctrl      = CW'($urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            wb_wdata  = $urandom;
            if (pend.size() > 0 && $urandom_range(1) != 0) begin
                wb_we = 1; wb_waddr = pend.pop_front();
            end else if ($urandom_range(19) == 0) begin
                wb_we = 1; wb_waddr = AW'($urandom_range(7));
            end else begin
                wb_we = 0; wb_waddr = '0;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
